// File: rtl/voice_allocator_pkg.sv
// Shared command-field positions and FSM encoding for the voice allocator.
// Command word layout: {on, note[6:0], vel[7:0]}; STOP_ALL is note-off of note 127.
package voice_allocator_pkg;

    localparam int CMD_ON_BIT   = 15;
    localparam int CMD_NOTE_MSB = 14;
    localparam int CMD_NOTE_LSB = 8;
    localparam int CMD_VEL_MSB  = 7;
    localparam int CMD_VEL_LSB  = 0;

    localparam logic [6:0] NOTE_ALL = 7'd127;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/voice_allocator_select.sv
// Combinational voice lookup: note match, lowest free voice, and oldest gated voice.
// All ties resolve to the lowest voice index.
module voice_allocator_select #(
    parameter int NUM_VOICES = 8,
    parameter int AGE_W      = 4,
    parameter int IDX_W      = $clog2(NUM_VOICES)
) (
    input  logic [NUM_VOICES-1:0]       gate_i,
    input  logic [7*NUM_VOICES-1:0]     note_i,
    input  logic [AGE_W*NUM_VOICES-1:0] age_i,
    input  logic [6:0]                  cmd_note_i,
    output logic                        match_hit_o,
    output logic [IDX_W-1:0]            match_idx_o,
    output logic                        free_hit_o,
    output logic [IDX_W-1:0]            free_idx_o,
    output logic [IDX_W-1:0]            oldest_idx_o
);

    logic [AGE_W-1:0] best_age;

    always_comb begin
        match_hit_o  = 1'b0;
        match_idx_o  = '0;
        free_hit_o   = 1'b0;
        free_idx_o   = '0;
        oldest_idx_o = '0;
        best_age     = '0;
        // Descending scan so the last hit written is the lowest index.
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (gate_i[i] && note_i[7*i +: 7] == cmd_note_i) begin
                match_hit_o = 1'b1;
                match_idx_o = IDX_W'(i);
            end
            if (!gate_i[i]) begin
                free_hit_o = 1'b1;
                free_idx_o = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (gate_i[i] && age_i[AGE_W*i +: AGE_W] > best_age) begin
                best_age     = age_i[AGE_W*i +: AGE_W];
                oldest_idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Maps note on/off commands onto NUM_VOICES voice banks with retrigger, oldest-voice
// stealing and a sequential STOP_ALL; one command per two clocks, ready only in IDLE.
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES  = 8,
    parameter int AGE_W       = 4,
    parameter bit STEAL_EN    = 1'b1,
    parameter bit VEL0_IS_OFF = 1'b1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              i_cmd_valid,
    input  logic [15:0]                       i_cmd,
    output logic                              o_cmd_ready,
    output logic [NUM_VOICES-1:0]             o_gate,
    output logic [NUM_VOICES-1:0]             o_trig,
    output logic [7*NUM_VOICES-1:0]           o_voice_note,
    output logic [8*NUM_VOICES-1:0]           o_voice_vel,
    output logic [$clog2(NUM_VOICES+1)-1:0]   o_active_cnt,
    output logic                              o_drop
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int CNT_W = $clog2(NUM_VOICES + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    state_e                      state_q, state_d;
    logic [15:0]                 cmd_q, cmd_d;
    logic [NUM_VOICES-1:0]       gate_q, gate_d, trig_q, trig_d;
    logic [7*NUM_VOICES-1:0]     note_q, note_d;
    logic [8*NUM_VOICES-1:0]     vel_q, vel_d;
    logic [AGE_W*NUM_VOICES-1:0] age_q, age_d;
    logic [IDX_W-1:0]            fidx_q, fidx_d;
    logic                        rdy_q, rdy_d, drop_q, drop_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    logic             match_hit, free_hit, is_on, do_alloc, reload;
    logic [IDX_W-1:0] match_idx, free_idx, oldest_idx, tgt;
    logic [6:0]       cmd_note;
    logic [7:0]       cmd_vel;

    assign cmd_note = cmd_q[CMD_NOTE_MSB:CMD_NOTE_LSB];
    assign cmd_vel  = cmd_q[CMD_VEL_MSB:CMD_VEL_LSB];

    voice_allocator_select #(
        .NUM_VOICES (NUM_VOICES),
        .AGE_W      (AGE_W),
        .IDX_W      (IDX_W)
    ) u_select (
        .gate_i       (gate_q),
        .note_i       (note_q),
        .age_i        (age_q),
        .cmd_note_i   (cmd_note),
        .match_hit_o  (match_hit),
        .match_idx_o  (match_idx),
        .free_hit_o   (free_hit),
        .free_idx_o   (free_idx),
        .oldest_idx_o (oldest_idx)
    );

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        gate_d   = gate_q;
        note_d   = note_q;
        vel_d    = vel_q;
        age_d    = age_q;
        fidx_d   = fidx_q;
        rdy_d    = rdy_q;
        trig_d   = '0;
        drop_d   = 1'b0;
        is_on    = cmd_q[CMD_ON_BIT] && !(VEL0_IS_OFF && cmd_vel == 8'd0);
        do_alloc = 1'b0;
        reload   = 1'b0;
        tgt      = '0;

        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid && rdy_q) begin
                    cmd_d  = i_cmd;
                    rdy_d  = 1'b0;
                    fidx_d = '0;
                    state_d = (!i_cmd[CMD_ON_BIT] && i_cmd[CMD_NOTE_MSB:CMD_NOTE_LSB] == NOTE_ALL)
                              ? ST_FLUSH : ST_APPLY;
                end
            end
            ST_APPLY: begin
                state_d = ST_IDLE;
                rdy_d   = 1'b1;
                if (is_on) begin
                    if (match_hit) begin
                        tgt      = match_idx;
                        do_alloc = 1'b1;
                    end else if (free_hit) begin
                        tgt      = free_idx;
                        do_alloc = 1'b1;
                        reload   = 1'b1;
                    end else if (STEAL_EN) begin
                        tgt      = oldest_idx;
                        do_alloc = 1'b1;
                        reload   = 1'b1;
                    end else begin
                        drop_d = 1'b1;
                    end
                    // Age counts allocations: every other sounding voice gets one tick older.
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (do_alloc && IDX_W'(i) == tgt) begin
                            gate_d[i]              = 1'b1;
                            trig_d[i]              = 1'b1;
                            age_d[AGE_W*i +: AGE_W] = '0;
                            vel_d[8*i +: 8]        = cmd_vel;
                            if (reload) note_d[7*i +: 7] = cmd_note;
                        end else if (do_alloc && gate_q[i] &&
                                     age_q[AGE_W*i +: AGE_W] != AGE_MAX) begin
                            age_d[AGE_W*i +: AGE_W] = age_q[AGE_W*i +: AGE_W] + 1'b1;
                        end
                    end
                end else if (match_hit) begin
                    gate_d[match_idx] = 1'b0;
                end
            end
            ST_FLUSH: begin
                gate_d[fidx_q] = 1'b0;
                if (fidx_q == IDX_W'(NUM_VOICES - 1)) begin
                    state_d = ST_IDLE;
                    rdy_d   = 1'b1;
                    fidx_d  = '0;
                end else begin
                    fidx_d = fidx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rdy_d   = 1'b1;
            end
        endcase

        cnt_d = '0;
        for (int i = 0; i < NUM_VOICES; i++) cnt_d = cnt_d + CNT_W'(gate_d[i]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            gate_q  <= '0;
            note_q  <= '0;
            vel_q   <= '0;
            age_q   <= '0;
            fidx_q  <= '0;
            rdy_q   <= 1'b1;
            trig_q  <= '0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            gate_q  <= gate_d;
            note_q  <= note_d;
            vel_q   <= vel_d;
            age_q   <= age_d;
            fidx_q  <= fidx_d;
            rdy_q   <= rdy_d;
            trig_q  <= trig_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_cmd_ready  = rdy_q;
    assign o_gate       = gate_q;
    assign o_trig       = trig_q;
    assign o_voice_note = note_q;
    assign o_voice_vel  = vel_q;
    assign o_active_cnt = cnt_q;
    assign o_drop       = drop_q;

endmodule
